frame_window_reader: RTL and testbench

- Reads a rectangular window of pixels out of the 160x120 frame memory, in raster order. Pixels within a row go left to right; rows go top to bottom.
- Issues read addresses to a synchronous-read pixel RAM/ROM port and returns a stream of (x, y, colour) beats under a valid/ready handshake.
- It is the read-side counterpart of the box/plot writers: those push x/y/colour/plot into the frame; this block pulls x/y/colour back out.
- The star-mapping logic uses it to scan a region for lit pixels.

---
 rtl/frame_window_reader.sv | 205 ++++++++++++++++++++
 tb/tb_frame_window_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_window_reader.sv
// frame_window_reader: raster-order read of a rectangular window of the 160x120 frame, returning (x, y, colour) beats.
// Latency: start is sampled on an edge and the first beat is valid two edges later; sustains 1 beat/cycle with outReady high.
// Backpressure: at most 2 reads outstanding (buffer + in flight); beats hold while outReady is low. Macro FRAME_WINDOW_READER_SKIP_BG_EN drops background pixels.
module frame_window_reader #(
    parameter int XSZ    = 8,
    parameter int YSZ    = 7,
    parameter int COLSZ  = 3,
    parameter int XRES   = 160,
    parameter int YRES   = 120,
    parameter int ADDRSZ = 15
`ifdef FRAME_WINDOW_READER_SKIP_BG_EN
    // Background colour exists only when background skipping is compiled in.
    , parameter logic [COLSZ-1:0] BG_COLOUR = '0
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [XSZ-1:0]    xLeft,
    input  logic [XSZ-1:0]    xRight,
    input  logic [YSZ-1:0]    yTop,
    input  logic [YSZ-1:0]    yBottom,
    output logic [ADDRSZ-1:0] memAddr,
    output logic              memRdEn,
    input  logic [COLSZ-1:0]  memData,
    output logic [XSZ-1:0]    xOut,
    output logic [YSZ-1:0]    yOut,
    output logic [COLSZ-1:0]  colOut,
    output logic              outValid,
    input  logic              outReady,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [XSZ-1:0] XMAX = XSZ'(XRES - 1);
    localparam logic [YSZ-1:0] YMAX = YSZ'(YRES - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t           r_state;
    logic [XSZ-1:0]   r_xl, r_xr, r_cx, r_ifx;
    logic [YSZ-1:0]   r_yb, r_cy, r_ify;
    logic             r_inflight;
    logic             r_busy, r_done, r_err;

    // Two-entry return buffer
    logic [XSZ-1:0]   r_fx [2];
    logic [YSZ-1:0]   r_fy [2];
    logic [COLSZ-1:0] r_fc [2];
    logic             r_wp, r_rp;
    logic [1:0]       r_cnt;

    logic             w_abort, w_pop, w_push, w_keep, w_issue, w_last, w_legal;
    logic [2:0]       w_outst, w_limit;
    logic [1:0]       w_cnt_next;
    logic [ADDRSZ-1:0] w_yext, w_xext;

    assign w_abort = abort && (r_state != S_IDLE);
    assign w_pop   = (r_cnt != 2'd0) && outReady;

    // A beat leaving this cycle frees a slot for the read issued now, which is what
    // lets the pipeline sustain one beat per cycle without ever overfilling the buffer.
    assign w_outst = {1'b0, r_cnt} + {2'b00, r_inflight};
    assign w_limit = 3'd2 + {2'b00, w_pop};
    assign w_issue = (r_state == S_SCAN) && !abort && (w_outst < w_limit);

`ifdef FRAME_WINDOW_READER_SKIP_BG_EN
    assign w_keep = (memData != BG_COLOUR);
`else
    assign w_keep = 1'b1;
`endif

    // Returning data is dropped when an abort is being taken this cycle.
    assign w_push     = r_inflight && !w_abort && w_keep;
    assign w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

    assign w_last  = (r_cx == r_xr) && (r_cy == r_yb);
    assign w_legal = (xLeft <= xRight) && (yTop <= yBottom) &&
                     (xRight <= XMAX) && (yBottom <= YMAX);

    // y*160 + x using shifts: y*128 + y*32 + x
    assign w_yext  = ADDRSZ'(r_cy);
    assign w_xext  = ADDRSZ'(r_cx);
    assign memAddr = (w_yext << 7) + (w_yext << 5) + w_xext;
    assign memRdEn = w_issue;

    assign outValid = (r_cnt != 2'd0);
    assign xOut     = r_fx[r_rp];
    assign yOut     = r_fy[r_rp];
    assign colOut   = r_fc[r_rp];
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

    // Control FSM: window latch, scan cursor, busy/done/err pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_xl    <= '0;
            r_xr    <= '0;
            r_yb    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_legal) begin
                            r_xl    <= xLeft;
                            r_xr    <= xRight;
                            r_yb    <= yBottom;
                            r_cx    <= xLeft;
                            r_cy    <= yTop;
                            r_busy  <= 1'b1;
                            r_state <= S_SCAN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_issue) begin
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else if (r_cx == r_xr) begin
                            r_cx <= r_xl;
                            r_cy <= r_cy + 1'b1;
                        end else begin
                            r_cx <= r_cx + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Finish as soon as the buffer will be empty after this edge;
                    // no read can be issued here, so nothing remains in flight.
                    if (abort || (w_cnt_next == 2'd0)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read pipeline: remember the coordinates of the read whose data arrives next cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inflight <= 1'b0;
            r_ifx      <= '0;
            r_ify      <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_ifx <= r_cx;
                r_ify <= r_cy;
            end
        end
    end

    // Output buffer: push returning pixels, pop on handshake, flush on abort
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                r_fx[i] <= '0;
                r_fy[i] <= '0;
                r_fc[i] <= '0;
            end
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else if (w_abort) begin
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_fx[r_wp] <= r_ifx;
                r_fy[r_wp] <= r_ify;
                r_fc[r_wp] <= memData;
                r_wp       <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_frame_window_reader.sv
// tb_frame_window_reader: table-driven windows, hand sequences for abort/reset, and random windows
// checked against a raster-order scoreboard built from the window bounds with plain loops.
module tb_frame_window_reader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  xLeft = '0, xRight = '0;
    logic [6:0]  yTop = '0, yBottom = '0;
    logic [14:0] memAddr;
    logic        memRdEn;
    logic [2:0]  memData = '0;
    logic [7:0]  xOut;
    logic [6:0]  yOut;
    logic [2:0]  colOut;
    logic        outValid;
    logic        outReady = 1'b0;
    logic        busy, done, err;

    frame_window_reader dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom),
        .memAddr(memAddr), .memRdEn(memRdEn), .memData(memData),
        .xOut(xOut), .yOut(yOut), .colOut(colOut), .outValid(outValid),
        .outReady(outReady), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mem_mode = 0;

    // Memory contents: mode 0 returns addr[2:0]; mode 1 gives colours 0,5,0,3 repeating
    function automatic logic [2:0] col_of(input int addr);
        if (mem_mode == 1) begin
            case (addr % 4)
                1:       return 3'd5;
                3:       return 3'd3;
                default: return 3'd0;
            endcase
        end
        return 3'(addr % 8);
    endfunction

    // Synchronous-read pixel memory
    always @(posedge clk) begin
        if (memRdEn) memData <= col_of(int'(memAddr));
    end

    typedef struct { int x; int y; int c; } beat_t;
    beat_t exp_q[$];

    typedef struct { int xl; int xr; int yt; int yb; int rmode; int exp_err; int exp_reads; int exp_addr; } vec_t;
    vec_t tbl[10];

    int cyc_n = 0;
    int first_valid, last_pop, done_cyc, n_rd, first_addr, outst, max_out, n_err_p, n_busy, n_pop;
    bit prev_stall;
    int px, py, pc;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc_n);
        end
    endtask

    task automatic clear_obs();
        first_valid = -1; last_pop = -1; done_cyc = -1; n_rd = 0; first_addr = -1;
        outst = 0; max_out = 0; n_err_p = 0; n_busy = 0; n_pop = 0; prev_stall = 1'b0;
        exp_q.delete();
    endtask

    // Expected beat stream: every pixel of a legal window, row by row, left to right
    task automatic build_model(input int xl, input int xr, input int yt, input int yb);
        beat_t b;
        if (xl <= xr && yt <= yb && xr < 160 && yb < 120) begin
            for (int y = yt; y <= yb; y++) begin
                for (int x = xl; x <= xr; x++) begin
                    b.x = x; b.y = y; b.c = int'(col_of(y * 160 + x));
`ifdef FRAME_WINDOW_READER_SKIP_BG_EN
                    if (b.c != 0) exp_q.push_back(b);
`else
                    exp_q.push_back(b);
`endif
                end
            end
        end
    endtask

    // Called at edge+1 once inputs are set; samples at edge+2 and returns at next edge+1
    task automatic observe();
        beat_t b;
        #1;
        if (prev_stall) begin
            chk("stall_hold_valid", int'(outValid), 1);
            chk("stall_hold_x", int'(xOut), px);
            chk("stall_hold_y", int'(yOut), py);
            chk("stall_hold_col", int'(colOut), pc);
        end
        if (outValid && first_valid < 0) first_valid = cyc_n;
        if (memRdEn) begin
            n_rd++;
            if (n_rd == 1) first_addr = int'(memAddr);
            outst++;
        end
        if (outValid && outReady) begin
            n_pop++;
            last_pop = cyc_n;
            outst--;
            if (exp_q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                chk("beat_x", int'(xOut), b.x);
                chk("beat_y", int'(yOut), b.y);
                chk("beat_col", int'(colOut), b.c);
            end
        end
        if (outst > max_out) max_out = outst;
        if (done && done_cyc < 0) done_cyc = cyc_n;
        if (err) n_err_p++;
        if (busy) n_busy++;
        prev_stall = outValid && !outReady;
        px = int'(xOut); py = int'(yOut); pc = int'(colOut);
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // rmode: 0 = ready always, 1 = ready 1,0,0 repeating, 2 = random ready
    task automatic run_win(input int xl, input int xr, input int yt, input int yb,
                           input int rmode, input int budget, output int start_cyc);
        bit legal;
        legal = (xl <= xr && yt <= yb && xr < 160 && yb < 120);
        clear_obs();
        build_model(xl, xr, yt, yb);
        xLeft = 8'(xl); xRight = 8'(xr); yTop = 7'(yt); yBottom = 7'(yb);
        start = 1'b1;
        outReady = 1'b1;
        start_cyc = cyc_n;
        observe();
        start = 1'b0;
        for (int k = 0; k < budget; k++) begin
            case (rmode)
                0:       outReady = 1'b1;
                1:       outReady = (k % 3 == 0);
                default: outReady = 1'($urandom_range(0, 1));
            endcase
            observe();
            if (done_cyc >= 0) break;
            if (!legal && k >= 3) break;
        end
        outReady = 1'b1;
    endtask

    task automatic post_checks(input int exp_err, input int exp_reads, input int exp_addr);
        if (exp_err != 0) begin
            chk("err_pulses", n_err_p, 1);
            chk("reads_on_illegal", n_rd, 0);
            chk("busy_on_illegal", n_busy, 0);
            chk("done_on_illegal", int'(done_cyc >= 0), 0);
        end else begin
            chk("err_on_legal", n_err_p, 0);
            chk("done_seen", int'(done_cyc >= 0), 1);
            chk("reads_issued", n_rd, exp_reads);
            chk("first_addr", first_addr, exp_addr);
            chk("beats_missing", exp_q.size(), 0);
            chk("outstanding_le2", int'(max_out <= 2), 1);
            chk("busy_after_done", int'(busy), 0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_memRdEn"}, int'(memRdEn), 0);
        chk({tag, "_memAddr"}, int'(memAddr), 0);
        chk({tag, "_outValid"}, int'(outValid), 0);
        chk({tag, "_xOut"}, int'(xOut), 0);
        chk({tag, "_yOut"}, int'(yOut), 0);
        chk({tag, "_colOut"}, int'(colOut), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc_n);
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int valid_after;
        int rd_after;
        int xl, xr, yt, yb, area;
        bit legal;

        tbl[0] = '{10, 12, 5, 6, 0, 0, 6, 810};
        tbl[1] = '{10, 12, 5, 6, 1, 0, 6, 810};
        tbl[2] = '{159, 159, 119, 119, 0, 0, 1, 19199};
        tbl[3] = '{20, 19, 0, 0, 0, 1, 0, 0};
        tbl[4] = '{0, 0, 5, 4, 0, 1, 0, 0};
        tbl[5] = '{0, 160, 0, 0, 0, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 120, 0, 1, 0, 0};
        tbl[7] = '{3, 3, 7, 7, 1, 0, 1, 1123};
        tbl[8] = '{150, 159, 118, 119, 2, 0, 20, 19030};
        tbl[9] = '{0, 159, 119, 119, 0, 0, 160, 19040};

        // Reset state
        #2;
        chk_zero("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven windows
        for (int i = 0; i < 10; i++) begin
            run_win(tbl[i].xl, tbl[i].xr, tbl[i].yt, tbl[i].yb, tbl[i].rmode, 400, s);
            post_checks(tbl[i].exp_err, tbl[i].exp_reads, tbl[i].exp_addr);
            if (i == 0) begin
                // start sampled at the end of cycle s; two edges later the first beat is valid
                chk("first_beat_latency", first_valid - s, 3);
                chk("beats_6", n_pop, 6);
                chk("done_after_last_pop", done_cyc - last_pop, 1);
            end
        end

        // Abort on the 3rd SCAN cycle of a full-frame scan
        clear_obs();
        build_model(0, 159, 0, 119);
        xLeft = 8'd0; xRight = 8'd159; yTop = 7'd0; yBottom = 7'd119;
        outReady = 1'b1;
        start = 1'b1;
        s = cyc_n;
        observe();
        start = 1'b0;
        observe();
        observe();
        abort = 1'b1;
        observe();
        abort = 1'b0;
        valid_after = 0;
        rd_after = n_rd;
        for (int k = 0; k < 6; k++) begin
            valid_after += int'(outValid);
            observe();
        end
        chk("abort_no_valid_after", valid_after, 0);
        chk("abort_no_reads_after", n_rd - rd_after, 0);
        chk("abort_done_seen", int'(done_cyc >= 0), 1);
        chk("abort_done_within_2", int'(done_cyc >= 0 && done_cyc - (s + 3) <= 2), 1);
        chk("abort_busy_low", int'(busy), 0);
        run_win(10, 12, 5, 6, 0, 400, s);
        post_checks(0, 6, 810);

        // Reset asserted in the middle of a scan
        clear_obs();
        build_model(0, 159, 0, 119);
        xLeft = 8'd0; xRight = 8'd159; yTop = 7'd0; yBottom = 7'd119;
        start = 1'b1;
        observe();
        start = 1'b0;
        for (int k = 0; k < 4; k++) observe();
        #2;
        resetn = 1'b0;
        #1;
        chk_zero("midscan_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_win(3, 6, 2, 3, 2, 400, s);
        post_checks(0, 8, 323);

`ifdef FRAME_WINDOW_READER_SKIP_BG_EN
        // Background pixels dropped: colours 0,5,0,3 give two beats
        mem_mode = 1;
        run_win(0, 3, 0, 0, 0, 400, s);
        post_checks(0, 4, 0);
        chk("skip_bg_beats", n_pop, 2);
        mem_mode = 0;
`endif

        // Random windows, occasionally illegal, with random backpressure
        for (int it = 0; it < 25; it++) begin
            xl = int'($urandom_range(0, 159));
            xr = xl + int'($urandom_range(0, 5));
            yt = int'($urandom_range(0, 119));
            yb = yt + int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                area = xl; xl = xr + 1; xr = area;
            end
            if (xr > 255) xr = 255;
            if (yb > 127) yb = 127;
            legal = (xl <= xr && yt <= yb && xr < 160 && yb < 120);
            area = legal ? (xr - xl + 1) * (yb - yt + 1) : 0;
            run_win(xl, xr, yt, yb, 2, 400, s);
            post_checks(legal ? 0 : 1, area, yt * 160 + xl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
